// File: rtl/shift_chain_ctrl_pkg.sv
// Shared types for the shift-chain controller: command opcodes and FSM states.
package shift_chain_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_SHIFT = 2'b01,
        OP_XCHG  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic op_loads(op_e op);
        return (op == OP_LOAD) || (op == OP_XCHG);
    endfunction

    function automatic logic op_shifts(op_e op);
        return (op == OP_SHIFT) || (op == OP_XCHG);
    endfunction

endpackage

// File: rtl/shift_chain_ctrl_if.sv
// Command/response handshake bundle between a host and shift_chain_ctrl.
interface shift_chain_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_chain_reg.sv
// WIDTH-bit loadable shift register; direction set by SHIFT_CHAIN_CTRL_LSB_FIRST_EN.
module shift_chain_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_sdi,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sdo
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
            r_q <= {i_sdi, r_q[WIDTH-1:1]};
`else
            r_q <= {r_q[WIDTH-2:0], i_sdi};
`endif
        end
    end

`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
    assign o_sdo = r_q[0];
`else
    assign o_sdo = r_q[WIDTH-1];
`endif

    assign o_q = r_q;
endmodule

// File: rtl/shift_chain_ctrl.sv
// Serial scan-chain controller: accepts LOAD/SHIFT/XCHG/NOP, shifts WIDTH bits, returns
// the register. Optional LSB-first shifting via SHIFT_CHAIN_CTRL_LSB_FIRST_EN.
module shift_chain_ctrl
    import shift_chain_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    shift_chain_ctrl_if.slave  bus,
    input  logic               sdi,
    output logic               sdo,
    output logic               shift_en,
    output logic               busy
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_armed;
    logic             w_cmd_ready;
    logic             w_shift_en;
    logic             w_rsp_valid;
    logic             w_busy;
    logic             w_accept;
    op_e              w_op;
    logic [WIDTH-1:0] w_q;
    logic             w_reg_sdo;

    assign w_op     = op_e'(bus.cmd_op);
    assign w_accept = bus.cmd_valid && w_cmd_ready;

    // r_armed holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_shift_en  = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy      = 1'b0;
                w_cmd_ready = r_armed;
                if (bus.cmd_valid && r_armed) begin
                    w_next = op_shifts(w_op) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    shift_chain_reg #(.WIDTH(WIDTH)) u_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept && op_loads(w_op)),
        .i_load_data (bus.cmd_data),
        .i_shift     (w_shift_en),
        .i_sdi       (sdi),
        .o_q         (w_q),
        .o_sdo       (w_reg_sdo)
    );

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = w_q;
    assign shift_en      = w_shift_en;
    assign sdo           = w_shift_en & w_reg_sdo;
    assign busy          = w_busy;
endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Self-checking bench for shift_chain_ctrl (WIDTH=8) with a bit-position reference model.
module tb_shift_chain_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sdi = 1'b0;
    logic sdo;
    logic shift_en;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] model_reg = '0;
    logic [W-1:0] rsp;

    shift_chain_ctrl_if #(.WIDTH(W)) bus ();

    shift_chain_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sdi      (sdi),
        .sdo      (sdo),
        .shift_en (shift_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit k of seq is the sdi value presented in shift cycle k.
    function automatic logic exp_sdo(input logic [W-1:0] init, input int k);
`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
        return init[k];
`else
        return init[W-1-k];
`endif
    endfunction

    function automatic logic [W-1:0] exp_final(input logic [W-1:0] seq);
        logic [W-1:0] f;
        for (int k = 0; k < W; k++) begin
`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
            f[k] = seq[k];
`else
            f[W-1-k] = seq[k];
`endif
        end
        return f;
    endfunction

    task automatic idle_outputs(input string tag);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_sdo"}, sdo, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                           input logic [W-1:0] seq, input int hold,
                           output logic [W-1:0] rsp_o);
        int waited;
        logic [W-1:0] init;
        logic shifting;
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        init     = (op == 2'b00 || op == 2'b10) ? data : model_reg;
        shifting = (op == 2'b01 || op == 2'b10);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.rsp_ready = 1'b0;
        step();
        if (shifting) begin
            for (int k = 0; k < W; k++) begin
                bus.cmd_valid = 1'($urandom);
                bus.cmd_op    = 2'($urandom);
                bus.cmd_data  = W'($urandom);
                chk("shift_en", shift_en, 1);
                chk("sdo", sdo, exp_sdo(init, k));
                chk("shift_rsp_valid", bus.rsp_valid, 0);
                chk("shift_cmd_ready", bus.cmd_ready, 0);
                sdi = seq[k];
                step();
            end
            model_reg = exp_final(seq);
        end else begin
            bus.cmd_valid = 1'b0;
            model_reg = init;
        end
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'($urandom);
            bus.cmd_op    = 2'($urandom);
            bus.cmd_data  = W'($urandom);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_data", bus.rsp_data, model_reg);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_busy", busy, 1);
            step();
        end
        chk("done_rsp_valid", bus.rsp_valid, 1);
        chk("done_rsp_data", bus.rsp_data, model_reg);
        chk("done_shift_en", shift_en, 0);
        chk("done_sdo", sdo, 0);
        rsp_o = bus.rsp_data;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        idle_outputs("post_hs");
        chk("post_hs_cmd_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b11;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #1;
        step();
        step();
        idle_outputs("rst");
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready_pre_edge", bus.cmd_ready, 0);
        step();
        chk("rel_cmd_ready_post_edge", bus.cmd_ready, 1);

        // LOAD 0xA5
        run_cmd(2'b00, 8'hA5, 8'h00, 0, rsp);
        chk("load_a5", rsp, 8'hA5);

`ifdef SHIFT_CHAIN_CTRL_LSB_FIRST_EN
        // XCHG 0x01 with sdi all ones
        run_cmd(2'b10, 8'h01, 8'hFF, 0, rsp);
        chk("xchg_01_lsb", rsp, 8'hFF);
`else
        // XCHG 0x81, sdi 0,1,0,1,...
        run_cmd(2'b10, 8'h81, 8'hAA, 0, rsp);
        chk("xchg_81", rsp, 8'h55);
`endif

        // Response back-pressure for 5 cycles
        run_cmd(2'b01, 8'h00, 8'h3B, 5, rsp);

        // NOP after LOAD 0x3C
        run_cmd(2'b00, 8'h3C, 8'h00, 0, rsp);
        run_cmd(2'b11, 8'hFF, 8'h00, 0, rsp);
        chk("nop_keeps_3c", rsp, 8'h3C);

        // Reset asserted at shift cycle 4
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_data  = 8'hC3;
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sdi = 1'($urandom);
            step();
        end
        chk("pre_abort_shift_en", shift_en, 1);
        rst = 1'b1;
        #1;
        idle_outputs("abort");
        chk("abort_rsp_data", bus.rsp_data, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 0);
        step();
        rst = 1'b0;
        model_reg = '0;
        #1;
        chk("abort_rel_cmd_ready_pre", bus.cmd_ready, 0);
        step();
        chk("abort_rel_cmd_ready", bus.cmd_ready, 1);
        chk("abort_no_rsp", bus.rsp_valid, 0);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            run_cmd(2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)), rsp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_chain_ctrl.md
SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, chain length in bits; SHALL be legal only for WIDTH >= 2.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-006 cmd_op  in  2  operation: 00 LOAD, 01 SHIFT, 10 XCHG, 11 NOP.
REQ-007 cmd_data  in  WIDTH  parallel load value for LOAD/XCHG.
REQ-008 sdi  in  1  serial data in from chain.
REQ-009 sdo  out  1  serial data out to chain.
REQ-010 shift_en  out  1  chain shift strobe, high for exactly one clk per bit.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clk edge.
REQ-013 rsp_data  out  WIDTH  internal chain register contents at completion.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 cmd_ready SHALL be high only in IDLE with rst low.
REQ-017 On acceptance, LOAD and XCHG SHALL write cmd_data into the chain register at the accepting edge; SHIFT and NOP SHALL leave it unchanged.
REQ-018 On acceptance, LOAD and NOP SHALL go to DONE, so rsp_valid is high in the cycle after acceptance.
REQ-019 On acceptance, SHIFT and XCHG SHALL go to SHIFT, clear the bit counter and shift for exactly WIDTH cycles (accept+1 .. accept+WIDTH).
REQ-020 In SHIFT, shift_en SHALL be 1 and sdo SHALL be reg[WIDTH-1]; each edge SHALL apply reg <= {reg[WIDTH-2:0], sdi}.
REQ-021 Outside SHIFT, shift_en and sdo SHALL be 0.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide, increment once per shift cycle, and leave SHIFT for DONE at the edge where the counter equals WIDTH-1.
REQ-023 rsp_valid SHALL be high in DONE only, i.e. at accept+WIDTH+1 for SHIFT/XCHG.
REQ-024 rsp_data SHALL equal the register and SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-025 When the DONE handshake completes, the FSM SHALL return to IDLE; a new command cannot be accepted in that same cycle (one-cycle bubble).
REQ-026 cmd_valid, cmd_op and cmd_data SHALL be ignored outside IDLE.

Reset
REQ-027 While rst is high, the FSM SHALL be in IDLE, the register and counter SHALL be 0, and every output SHALL be 0, including cmd_ready.
REQ-028 Asserting rst mid-SHIFT or mid-DONE SHALL abort the operation immediately with no response.
REQ-029 cmd_ready SHALL rise at the first clk edge after rst deasserts.

Configuration
REQ-030 With SHIFT_CHAIN_CTRL_LSB_FIRST_EN undefined, shifting SHALL be MSB-first as in REQ-020.
REQ-031 With SHIFT_CHAIN_CTRL_LSB_FIRST_EN defined, sdo SHALL be reg[0] and the shift SHALL be reg <= {sdi, reg[WIDTH-1:1]}.
REQ-032 Under SHIFT_CHAIN_CTRL_LSB_FIRST_EN, all other timing SHALL be identical.

Structure
REQ-033 Package shift_chain_ctrl_pkg SHALL hold the cmd_op encodings (OP_LOAD, OP_SHIFT, OP_XCHG, OP_NOP) and the FSM state type.
REQ-034 Sub-module shift_chain_reg SHALL implement the WIDTH-bit loadable shift register with async reset.
REQ-035 The FSM and the bit counter SHALL stay in shift_chain_ctrl.

Verification (WIDTH=8)
REQ-036 LOAD 0xA5 -> rsp_valid at accept+1, rsp_data=0xA5, shift_en never high.
REQ-037 XCHG 0x81 with sdi 0,1,0,1,0,1,0,1 -> sdo 1,0,0,0,0,0,0,1 over accept+1..+8, rsp_valid at accept+9, rsp_data=0x55.
REQ-038 rsp_ready held low 5 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready 0, busy 1; cmd_ready 1 the cycle after the handshake.
REQ-039 rst pulsed at shift cycle 4 -> shift_en, sdo, busy and rsp_valid 0 at once, register 0, no rsp; cmd_ready 1 one edge after release.
REQ-040 NOP after LOAD 0x3C -> rsp_valid at accept+1, rsp_data=0x3C, no shift_en.
REQ-041 With SHIFT_CHAIN_CTRL_LSB_FIRST_EN, XCHG 0x01 with sdi all 1 -> sdo 1,0,0,0,0,0,0,0, rsp_data=0xFF.
